hazard_scoreboard: RTL and testbench



---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_scoreboard_if.sv | 38 +++
 rtl/hazard_entry_match.sv | 26 ++
 rtl/hazard_scoreboard.sv | 116 +++++++++++
 tb/tb_hazard_scoreboard.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the decode-stage RAW hazard scoreboard.
// - REG_W_DEF   : default register-index width (8 architectural registers).
// - NOP_INSN    : NOP encoding. The ID decoder drives id_valid low for it.
// - hazardEntryT: one in-flight window entry {valid, dest, isLoad} at the
//                 default width. The parametrised top declares the same
//                 layout at its own width.
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int          REG_W_DEF = 3;
    localparam logic [15:0] NOP_INSN  = 16'h0800;

    typedef struct packed {
        logic                 valid;
        logic [REG_W_DEF-1:0] dest;
        logic                 isLoad;
    } hazardEntryT;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
// Bundles the ID-stage instruction description and the stall outputs.
//   master: the decode stage. It drives id_* and flush, and receives
//           stall_n and stall_count.
//   slave : the scoreboard. It receives id_* and flush, and drives
//           stall_n and stall_count.
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_writes;
    logic [REG_W-1:0] id_dest;
    logic             id_is_load;
    logic             flush;
    logic             stall_n;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_writes, id_dest, id_is_load, flush,
        input  stall_n, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_writes, id_dest, id_is_load, flush,
        output stall_n, stall_count
    );
endinterface

// File: rtl/hazard_entry_match.sv
// -----------------------------------------------------------------------------
// hazard_entry_match
// Combinational comparator for a single in-flight entry.
//   entryValid/entryDest : the registered window entry.
//   rs/rt, usesRs/usesRt : sources of the decoding instruction. The caller
//                          gates usesRs/usesRt with id_valid.
//   match                : the entry writes a register that the decoding
//                          instruction reads.
// -----------------------------------------------------------------------------
module hazard_entry_match
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             entryValid,
    input  logic [REG_W-1:0] entryDest,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             usesRs,
    input  logic             usesRt,
    output logic             match
);
    // Full-width equality: no register index is hardwired to zero.
    assign match = entryValid &&
                   ((usesRs && (entryDest == rs)) || (usesRt && (entryDest == rt)));
endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Decode-stage RAW hazard detector. It tracks the destinations of the
// STAGES instructions after ID in a shift register (entry 0 = EX, entry
// STAGES-1 = oldest). It compares the ID sources against that window and
// drops stall_n to hold PC/IF-ID and inject a NOP into ID/EX.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset.
//   bus (slave): id_* instruction description and flush in;
//                stall_n (combinational) and stall_count (saturating) out.
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W     = REG_W_DEF,
    parameter int STAGES    = 3,
    parameter int RF_BYPASS = 1,
    parameter int FWD_EN    = 0,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_scoreboard_if.slave  bus
);
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             isLoad;
    } entryT;

    // With write-before-read the oldest entry already reaches the register
    // file in time, so it drops out of the compared set.
    localparam int CMP_DEPTH = (RF_BYPASS != 0) ? STAGES - 1 : STAGES;

    entryT             window [STAGES];
    logic [STAGES-1:0] entryMatch;
    logic [STAGES-1:0] cmpMask;
    logic              hazard;
    logic              stallN;
    logic [CNT_W-1:0]  stallCount;

    // A bubble in ID must not compare its don't-care source fields.
    logic usesRsQ;
    logic usesRtQ;
    assign usesRsQ = bus.id_valid && bus.id_uses_rs;
    assign usesRtQ = bus.id_valid && bus.id_uses_rt;

    for (genvar g = 0; g < STAGES; g++) begin : gMatch
        assign cmpMask[g] = (g < CMP_DEPTH);

        hazard_entry_match #(.REG_W(REG_W)) uMatch (
            .entryValid (window[g].valid),
            .entryDest  (window[g].dest),
            .rs         (bus.id_rs),
            .rt         (bus.id_rt),
            .usesRs     (usesRsQ),
            .usesRt     (usesRtQ),
            .match      (entryMatch[g])
        );
    end

    // NOTE: assign a default at the top of every always_comb so that no path
    // leaves the output unassigned. That prevents a latch from being inferred.
    always_comb begin
        hazard = 1'b0;
        if (FWD_EN != 0) begin
            // Forwarding covers every case except a load result still in EX.
            hazard = entryMatch[0] && window[0].isLoad;
        end else begin
            hazard = |(entryMatch & cmpMask);
        end
    end

    // A flush squashes the instruction in ID, so it never asks for a stall.
    assign stallN = !(bus.id_valid && !bus.flush && hazard);

    // NOTE: the window holds valid bits that control behaviour, so it is a
    // flop array and it is reset. It is not a RAM.
    // Sequential state uses non-blocking assignments so that every entry
    // reads its neighbour's value from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                window[i] <= '0;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < STAGES; i++) begin
                window[i] <= '0;
            end
        end else begin
            // The window keeps shifting while stalled, so every hazard
            // drains within STAGES cycles.
            for (int i = STAGES - 1; i > 0; i--) begin
                window[i] <= window[i-1];
            end
            if (!stallN) begin
                window[0] <= '0;
            end else begin
                window[0] <= '{valid:  bus.id_valid && bus.id_writes,
                               dest:   bus.id_dest,
                               isLoad: bus.id_is_load};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCount <= '0;
        end else if (!stallN && (stallCount != '1)) begin
            stallCount <= stallCount + CNT_W'(1);
        end
    end

    assign bus.stall_n     = stallN;
    assign bus.stall_count = stallCount;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Four scoreboards share one stimulus stream:
//   A: defaults
//   B: RF_BYPASS=0
//   C: FWD_EN=1
//   D: CNT_W=2
// Each table row gives the ID inputs for one cycle, the expected stall_n of
// every instance (bit 3 = A .. bit 0 = D), and the stall counts visible in
// that cycle. Hand-written sequences follow the table for flush and for an
// asynchronous reset during a stall.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    typedef struct {
        logic       valid;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       usesRs;
        logic       usesRt;
        logic       writes;
        logic [2:0] dest;
        logic       isLoad;
        logic       flush;
        logic [3:0] expN;
        int         cntA, cntB, cntC, cntD;
    } vecT;

    localparam int NVEC = 28;

    logic clk;
    logic rst_n;
    int   nChecks = 0;
    int   nFail   = 0;
    vecT  vecs [NVEC];

    hazard_scoreboard_if #(.REG_W(3), .CNT_W(16)) busA ();
    hazard_scoreboard_if #(.REG_W(3), .CNT_W(16)) busB ();
    hazard_scoreboard_if #(.REG_W(3), .CNT_W(16)) busC ();
    hazard_scoreboard_if #(.REG_W(3), .CNT_W(2))  busD ();

    hazard_scoreboard                  dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
    hazard_scoreboard #(.RF_BYPASS(0)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));
    hazard_scoreboard #(.FWD_EN(1))    dutC (.clk(clk), .rst_n(rst_n), .bus(busC));
    hazard_scoreboard #(.CNT_W(2))     dutD (.clk(clk), .rst_n(rst_n), .bus(busD));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vecT mk(input int vl, input int rs, input int rt,
                               input int ur, input int ut, input int wr,
                               input int dst, input int ld, input int fl,
                               input logic [3:0] expN,
                               input int cA, input int cB, input int cC, input int cD);
        vecT v;
        v.valid  = 1'(vl);
        v.rs     = 3'(rs);
        v.rt     = 3'(rt);
        v.usesRs = 1'(ur);
        v.usesRt = 1'(ut);
        v.writes = 1'(wr);
        v.dest   = 3'(dst);
        v.isLoad = 1'(ld);
        v.flush  = 1'(fl);
        v.expN   = expN;
        v.cntA   = cA;
        v.cntB   = cB;
        v.cntC   = cC;
        v.cntD   = cD;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic driveVec(input vecT v);
        busA.id_valid = v.valid; busA.id_rs = v.rs; busA.id_rt = v.rt;
        busA.id_uses_rs = v.usesRs; busA.id_uses_rt = v.usesRt; busA.id_writes = v.writes;
        busA.id_dest = v.dest; busA.id_is_load = v.isLoad; busA.flush = v.flush;
        busB.id_valid = v.valid; busB.id_rs = v.rs; busB.id_rt = v.rt;
        busB.id_uses_rs = v.usesRs; busB.id_uses_rt = v.usesRt; busB.id_writes = v.writes;
        busB.id_dest = v.dest; busB.id_is_load = v.isLoad; busB.flush = v.flush;
        busC.id_valid = v.valid; busC.id_rs = v.rs; busC.id_rt = v.rt;
        busC.id_uses_rs = v.usesRs; busC.id_uses_rt = v.usesRt; busC.id_writes = v.writes;
        busC.id_dest = v.dest; busC.id_is_load = v.isLoad; busC.flush = v.flush;
        busD.id_valid = v.valid; busD.id_rs = v.rs; busD.id_rt = v.rt;
        busD.id_uses_rs = v.usesRs; busD.id_uses_rt = v.usesRt; busD.id_writes = v.writes;
        busD.id_dest = v.dest; busD.id_is_load = v.isLoad; busD.flush = v.flush;
    endtask

    task automatic checkAll(input string tag, input vecT v);
        check({tag, " stall_n A"}, int'(busA.stall_n), int'(v.expN[3]));
        check({tag, " stall_n B"}, int'(busB.stall_n), int'(v.expN[2]));
        check({tag, " stall_n C"}, int'(busC.stall_n), int'(v.expN[1]));
        check({tag, " stall_n D"}, int'(busD.stall_n), int'(v.expN[0]));
        check({tag, " count A"}, int'(busA.stall_count), v.cntA);
        check({tag, " count B"}, int'(busB.stall_count), v.cntB);
        check({tag, " count C"}, int'(busC.stall_count), v.cntC);
        check({tag, " count D"}, int'(busD.stall_count), v.cntD);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecT bub, add2, cons2, cons6;
        bub   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 0, 0, 0);
        add2  = mk(1, 1, 3, 1, 1, 1, 2, 0, 0, 4'b1111, 0, 0, 0, 0);
        cons2 = mk(1, 2, 4, 1, 1, 1, 6, 0, 0, 4'b1111, 0, 0, 0, 0);

        // RAW on r2 back-to-back, then a bubble carrying garbage fields.
        vecs[0]  = mk(1, 1, 3, 1, 1, 1, 2, 0, 0, 4'b1111, 0, 0, 0, 0);
        vecs[1]  = mk(1, 2, 4, 1, 1, 1, 6, 0, 0, 4'b0010, 0, 0, 0, 0);
        vecs[2]  = mk(1, 2, 4, 1, 1, 1, 6, 0, 0, 4'b0010, 1, 1, 0, 1);
        vecs[3]  = mk(1, 2, 4, 1, 1, 1, 6, 0, 0, 4'b1011, 2, 2, 0, 2);
        vecs[4]  = mk(0, 6, 6, 1, 1, 1, 6, 0, 0, 4'b1111, 2, 3, 0, 2);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 2, 3, 0, 2);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 2, 3, 0, 2);
        // Independent pair: dest r2, then sources r3/r4.
        vecs[7]  = mk(1, 1, 3, 1, 1, 1, 2, 0, 0, 4'b1111, 2, 3, 0, 2);
        vecs[8]  = mk(1, 3, 4, 1, 1, 1, 5, 0, 0, 4'b1111, 2, 3, 0, 2);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 2, 3, 0, 2);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 2, 3, 0, 2);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 2, 3, 0, 2);
        // Load r5, then a consumer reading rt=r5.
        vecs[12] = mk(1, 1, 0, 1, 0, 1, 5, 1, 0, 4'b1111, 2, 3, 0, 2);
        vecs[13] = mk(1, 0, 5, 1, 1, 1, 7, 0, 0, 4'b0000, 2, 3, 0, 2);
        vecs[14] = mk(1, 0, 5, 1, 1, 1, 7, 0, 0, 4'b0010, 3, 4, 1, 3);
        vecs[15] = mk(1, 0, 5, 1, 1, 1, 7, 0, 0, 4'b1011, 4, 5, 1, 3);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 4, 6, 1, 3);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 4, 6, 1, 3);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 4, 6, 1, 3);
        // ALU r5, then a consumer reading rt=r5, then a non-reader with rt=r5.
        vecs[19] = mk(1, 1, 3, 1, 1, 1, 5, 0, 0, 4'b1111, 4, 6, 1, 3);
        vecs[20] = mk(1, 0, 5, 0, 1, 1, 7, 0, 0, 4'b0010, 4, 6, 1, 3);
        vecs[21] = mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 4'b1111, 5, 7, 1, 3);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 5, 7, 1, 3);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 5, 7, 1, 3);
        // Load r5, then an instruction with rt=r5 that reads neither source.
        vecs[24] = mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 4'b1111, 5, 7, 1, 3);
        vecs[25] = mk(1, 5, 5, 0, 0, 0, 0, 0, 0, 4'b1111, 5, 7, 1, 3);
        vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 5, 7, 1, 3);
        vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 5, 7, 1, 3);

        // Reset state.
        rst_n = 1'b0;
        driveVec(cons2);
        @(negedge clk);
        checkAll("reset", bub);
        #7 rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1 driveVec(vecs[i]);
            @(negedge clk);
            checkAll($sformatf("v%0d", i), vecs[i]);
        end

        // Flush on the first cycle of a RAW stall.
        @(posedge clk); #1 driveVec(add2);
        @(negedge clk); check("flush pre stall_n A", int'(busA.stall_n), 1);
        cons6 = cons2;
        cons6.flush = 1'b1;
        @(posedge clk); #1 driveVec(cons6);
        @(negedge clk);
        check("flush cycle stall_n A", int'(busA.stall_n), 1);
        check("flush cycle stall_n B", int'(busB.stall_n), 1);
        @(posedge clk); #1 driveVec(cons2);
        @(negedge clk);
        check("flush after stall_n A", int'(busA.stall_n), 1);
        check("flush after stall_n B", int'(busB.stall_n), 1);
        check("flush after count A", int'(busA.stall_count), 5);
        @(posedge clk); #1 driveVec(bub);

        // Asynchronous reset between edges, in the middle of a stall.
        @(posedge clk); #1 driveVec(add2);
        @(posedge clk); #1 driveVec(cons2);
        @(negedge clk); check("rst pre stall_n A", int'(busA.stall_n), 0);
        @(posedge clk); #1;
        check("rst mid stall_n A", int'(busA.stall_n), 0);
        check("rst mid count A", int'(busA.stall_count), 6);
        #1 rst_n = 1'b0;
        #1;
        check("rst async stall_n A", int'(busA.stall_n), 1);
        check("rst async count A", int'(busA.stall_count), 0);
        check("rst async count D", int'(busD.stall_count), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst after stall_n A", int'(busA.stall_n), 1);
        check("rst after stall_n B", int'(busB.stall_n), 1);
        @(posedge clk); #1 driveVec(bub);
        @(negedge clk); check("rst after count A", int'(busA.stall_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end
endmodule
